cache_pipe_reg_elastic: RTL

Parametrised, multi-stage elastic pipeline register for the cache read/write datapath. It is the successor to the single-stage enable/reset flop for cache pipeline records. It adds a per-stage valid bit, a valid/ready handshake on both sides, bubble collapse, flush, and an occupancy counter. It sits between cache pipeline stages (tag lookup -> data read -> response), carrying packed cache pipeline records as flat vectors.

---
 rtl/cache_pipe_reg_elastic.sv | 109 ++++++++++
 1 files changed

// File: rtl/cache_pipe_reg_elastic.sv
// Elastic multi-stage pipeline register for cache pipeline records.
// Each stage holds a valid bit and a record. Empty stages always accept from upstream,
// so bubbles collapse and up to DEPTH entries are buffered under backpressure.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (highest priority)
//   en         global advance enable; 0 freezes all stages
//   flush      synchronous kill of all in-flight entries
//   in_valid   upstream entry present
//   in_ready   block accepts in_data this cycle
//   in_data    upstream record
//   out_valid  last stage holds a valid entry (masked during flush)
//   out_ready  downstream accepts out_data
//   out_data   record held by the last stage
//   occupancy  number of valid stages
module cache_pipe_reg_elastic #(
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned DEPTH          = 2,
  parameter bit          CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned CW             = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    occupancy
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [CW-1:0]    occ_q, occ_d;

  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] up_data [DEPTH];
  logic             in_fire, out_fire;

  // Stage k may advance when enabled and some stage at or after k is empty, or the output
  // drains. Accumulating "a hole exists downstream" avoids a self-referencing chain.
  always_comb begin
    logic hole;
    hole = out_ready;
    adv  = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      hole   = hole || !valid_q[k];
      adv[k] = en && !flush && hole;
    end
  end

  always_comb begin
    up_valid[0] = in_valid;
    up_data[0]  = in_data;
    for (int k = 1; k < int'(DEPTH); k++) begin
      up_valid[k] = valid_q[k-1];
      up_data[k]  = data_q[k-1];
    end
  end

  assign in_ready  = adv[0];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = valid_q[DEPTH-1] && out_ready && en && !flush;
  assign out_valid = valid_q[DEPTH-1] && !flush;
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;
  assign occ_d     = occ_q + CW'(in_fire) - CW'(out_fire);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int k = 0; k < int'(DEPTH); k++) data_q[k] <= '0;
    end else if (flush) begin
      valid_q <= '0;
      occ_q   <= '0;
      if (CLEAR_ON_FLUSH) begin
        for (int k = 0; k < int'(DEPTH); k++) data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (adv[k]) begin
          valid_q[k] <= up_valid[k];
          // A bubble moving in leaves the stale record in place.
          if (up_valid[k]) data_q[k] <= up_data[k];
        end
      end
      occ_q <= occ_d;
    end
  end

  a_out_stable : assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready && en) |=> $stable(out_data));

  a_no_fire_on_flush : assert property (@(posedge clk) disable iff (reset)
    flush |-> !in_fire);

  a_occ_bound : assert property (@(posedge clk) disable iff (reset)
    32'(occ_q) <= DEPTH);

  a_occ_popcount : assert property (@(posedge clk) disable iff (reset)
    $countones(valid_q) == 32'(occ_q));

endmodule
